// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: drives PC inc/jmp, issues memory reads, hands words to decode.
// Define FETCH_PERF_CNT_EN to add saturating perf_issued/perf_flushed counters.
module fetch_ctrl #(
    parameter int ADDR_WIDTH  = 8,
    parameter int INSTR_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   halt,
    input  logic [ADDR_WIDTH-1:0]  pc_addr,
    output logic                   pc_inc,
    output logic                   pc_jmp,
    output logic [ADDR_WIDTH-1:0]  pc_jmp_addr,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [ADDR_WIDTH-1:0]  mem_req_addr,
    input  logic                   mem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] mem_rsp_data,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0]  instr_addr,
    input  logic                   br_valid,
    input  logic [ADDR_WIDTH-1:0]  br_target,
    output logic                   busy
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]            perf_issued,
    output logic [15:0]            perf_flushed
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        ISSUE = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t                 state_reg;
    state_t                 resume_state;
    logic [INSTR_WIDTH-1:0] instr_data_reg;
    logic [ADDR_WIDTH-1:0]  instr_addr_reg;
    logic                   run_ok;
    logic                   req_fire;
    logic                   issue_fire;

    assign run_ok       = en && !halt;
    assign resume_state = run_ok ? REQ : IDLE;

    // A branch pulse masks the request/issue valids in the same cycle.
    assign mem_req_valid = (state_reg == REQ) && !br_valid;
    assign mem_req_addr  = pc_addr;
    assign req_fire      = mem_req_valid && mem_req_ready;

    assign instr_valid = (state_reg == ISSUE) && !br_valid;
    assign issue_fire  = instr_valid && instr_ready;
    assign instr_data  = instr_data_reg;
    assign instr_addr  = instr_addr_reg;

    assign pc_inc      = (state_reg == WAIT) && mem_rsp_valid && !br_valid;
    assign pc_jmp      = br_valid;
    assign pc_jmp_addr = br_valid ? br_target : '0;

    assign busy = (state_reg != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            instr_data_reg <= '0;
            instr_addr_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!br_valid && run_ok) begin
                        state_reg <= REQ;
                    end
                end
                REQ: begin
                    if (req_fire) begin
                        instr_addr_reg <= pc_addr;
                        state_reg      <= WAIT;
                    end
                end
                WAIT: begin
                    if (br_valid) begin
                        // Without the response in hand it is still owed; swallow it in DRAIN.
                        state_reg <= mem_rsp_valid ? resume_state : DRAIN;
                    end else if (mem_rsp_valid) begin
                        instr_data_reg <= mem_rsp_data;
                        state_reg      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (br_valid || issue_fire) begin
                        state_reg <= resume_state;
                    end
                end
                DRAIN: begin
                    // The stale response always ends DRAIN, even if another branch lands with it.
                    if (mem_rsp_valid) begin
                        state_reg <= resume_state;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_issued_reg;
    logic [15:0] perf_flushed_reg;
    logic        flush_event;

    // A branch in WAIT or ISSUE abandons exactly one fetched (or owed) word.
    assign flush_event = br_valid && ((state_reg == WAIT) || (state_reg == ISSUE));

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issued_reg  <= '0;
            perf_flushed_reg <= '0;
        end else begin
            if (issue_fire && (perf_issued_reg != 16'hFFFF)) begin
                perf_issued_reg <= perf_issued_reg + 16'd1;
            end
            if (flush_event && (perf_flushed_reg != 16'hFFFF)) begin
                perf_flushed_reg <= perf_flushed_reg + 16'd1;
            end
        end
    end

    assign perf_issued  = perf_issued_reg;
    assign perf_flushed = perf_flushed_reg;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: PC register + variable-latency memory environment, transaction
// scoreboard tracking the expected fetch address stream, directed scenarios then random traffic.
module tb_fetch_ctrl;
    localparam int AW = 8;
    localparam int IW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, en, halt;
    logic [AW-1:0] pc_addr;
    logic          pc_inc, pc_jmp;
    logic [AW-1:0] pc_jmp_addr;
    logic          mem_req_valid, mem_req_ready;
    logic [AW-1:0] mem_req_addr;
    logic          mem_rsp_valid;
    logic [IW-1:0] mem_rsp_data;
    logic          instr_valid, instr_ready;
    logic [IW-1:0] instr_data;
    logic [AW-1:0] instr_addr;
    logic          br_valid;
    logic [AW-1:0] br_target;
    logic          busy;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0]   perf_issued, perf_flushed;
`endif

    fetch_ctrl #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) dut (
        .clk(clk), .rst(rst), .en(en), .halt(halt), .pc_addr(pc_addr),
        .pc_inc(pc_inc), .pc_jmp(pc_jmp), .pc_jmp_addr(pc_jmp_addr),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_addr(instr_addr),
        .br_valid(br_valid), .br_target(br_target), .busy(busy)
`ifdef FETCH_PERF_CNT_EN
        , .perf_issued(perf_issued), .perf_flushed(perf_flushed)
`endif
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        return 16'hA000 + {8'h00, a};
    endfunction

    // Environment and scoreboard state
    int            cyc = 0;
    int            lat = 1;
    bit            beef_next = 0;
    bit            pend = 0;
    int            cnt = 0;
    logic [IW-1:0] pend_data = '0;
    bit            live = 0;
    logic [AW-1:0] live_addr = '0;
    bit            holding = 0;
    logic [AW-1:0] hold_addr = '0;
    logic [IW-1:0] hold_data = '0;
    logic [AW-1:0] exp_next = '0;
    int            n_req = 0, n_inc = 0, n_issue = 0, req_while_pend = 0, beef_seen = 0;
    logic [AW-1:0] iss_addr[$];
    logic [IW-1:0] iss_data[$];
    int            iss_cyc[$];

    logic          o_busy, o_req_valid, o_req_acc, o_inc, o_jmp, o_iv, o_hs, o_rsp;
    logic [AW-1:0] o_jmp_addr, o_req_addr, o_instr_addr;
    logic [IW-1:0] o_instr_data;

    // One clock: memory drives its response, outputs are checked mid-cycle, then the
    // PC register and the expected-stream model advance just after the edge.
    task automatic step();
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        if (pend) begin
            cnt--;
            if (cnt <= 0) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = pend_data;
            end
        end
        #1;
        o_busy = busy; o_req_valid = mem_req_valid; o_inc = pc_inc; o_jmp = pc_jmp;
        o_iv = instr_valid; o_jmp_addr = pc_jmp_addr; o_req_addr = mem_req_addr;
        o_instr_addr = instr_addr; o_instr_data = instr_data; o_rsp = mem_rsp_valid;
        o_req_acc = mem_req_valid && mem_req_ready;
        o_hs = instr_valid && instr_ready;
        if (!rst) begin
            check("pc_jmp", 32'(pc_jmp), 32'(br_valid));
            check("pc_jmp_addr", 32'(pc_jmp_addr), 32'(br_valid ? br_target : 8'h00));
            check("inc_jmp_exclusive", 32'(pc_inc && pc_jmp), 32'd0);
            check("req_addr_is_pc", 32'(mem_req_addr), 32'(pc_addr));
            check("pc_inc", 32'(pc_inc), 32'(mem_rsp_valid && live && !br_valid));
            check("instr_valid", 32'(instr_valid), 32'(holding && !br_valid));
            if (holding) begin
                check("instr_data", 32'(instr_data), 32'(hold_data));
                check("instr_addr", 32'(instr_addr), 32'(hold_addr));
            end
            if (mem_req_valid) check("req_while_fetching", 32'(live || holding || br_valid), 32'd0);
            if (o_req_acc) begin
                n_req++;
                if (pend) req_while_pend++;
                check("req_sequence", 32'(mem_req_addr), 32'(exp_next));
            end
            if (o_hs) begin
                n_issue++;
                iss_addr.push_back(instr_addr);
                iss_data.push_back(instr_data);
                iss_cyc.push_back(cyc);
                if (instr_data == 16'hBEEF) beef_seen++;
                $display("[%0d] issue addr=0x%02h data=0x%04h", cyc, instr_addr, instr_data);
            end
            if (pc_inc) n_inc++;
        end
        @(posedge clk);
        #1;
        if (rst) begin
            live = 0; holding = 0; exp_next = '0; pc_addr = '0;
        end else begin
            if (o_req_acc) begin
                live = 1; live_addr = pc_addr; pend = 1; cnt = lat;
                pend_data = beef_next ? 16'hBEEF : mem_word(pc_addr);
            end
            if (o_rsp && live) begin
                if (!br_valid) begin
                    holding = 1; hold_addr = live_addr; hold_data = mem_rsp_data;
                end
                live = 0;
            end
            if (br_valid) begin
                live = 0; holding = 0; exp_next = br_target;
            end
            if (o_hs) begin
                holding = 0; exp_next = hold_addr + 8'd1;
            end
            pc_addr = o_jmp ? o_jmp_addr : (o_inc ? pc_addr + 8'd1 : pc_addr);
        end
        if (o_rsp) pend = 0;
        cyc++;
        @(negedge clk);
    endtask

    task automatic wait_hs(input int budget);
        bit got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            step();
            got = o_hs;
        end
        check("issue_timeout", 32'(got), 32'd1);
    endtask

    task automatic wait_req(input int budget);
        bit got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            step();
            got = o_req_acc;
        end
        check("request_timeout", 32'(got), 32'd1);
        if (got) $display("[%0d] request addr=0x%02h", cyc, o_req_addr);
    endtask

    task automatic wait_iv(input int budget);
        bit got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            step();
            got = o_iv;
        end
        check("valid_timeout", 32'(got), 32'd1);
    endtask

    initial begin
        int r0, i0, k0, good;
        logic [AW-1:0] a0;
        logic [IW-1:0] d0;

        rst = 1; en = 0; halt = 0; mem_req_ready = 1; instr_ready = 1;
        br_valid = 0; br_target = '0; pc_addr = '0; mem_rsp_valid = 0; mem_rsp_data = '0;
        @(negedge clk);
        step(); step();
        rst = 0;
        step();
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_instr_valid", 32'(o_iv), 32'd0);
        check("rst_instr_data", 32'(o_instr_data), 32'd0);
        check("rst_instr_addr", 32'(o_instr_addr), 32'd0);
        check("rst_req_valid", 32'(o_req_valid), 32'd0);
        check("rst_pc_inc", 32'(o_inc), 32'd0);

        // Sequential fetch, 1-cycle memory
        en = 1; i0 = n_inc;
        wait_hs(10); wait_hs(10); wait_hs(10);
        check("seq_count", 32'(iss_addr.size()), 32'd3);
        if (iss_addr.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                check("seq_addr", 32'(iss_addr[i]), 32'(i));
                check("seq_data", 32'(iss_data[i]), 32'h0000A000 + 32'(i));
            end
            check("seq_spacing_1", 32'(iss_cyc[1] - iss_cyc[0]), 32'd3);
            check("seq_spacing_2", 32'(iss_cyc[2] - iss_cyc[1]), 32'd3);
        end
        check("seq_pc_inc_count", 32'(n_inc - i0), 32'd3);

        // Backpressure: decoder stalls with an instruction presented
        instr_ready = 0;
        wait_iv(10);
        a0 = o_instr_addr; d0 = o_instr_data; r0 = n_req; i0 = n_inc; good = 0;
        check("bp_addr", 32'(a0), 32'd3);
        check("bp_data", 32'(d0), 32'h0000A003);
        for (int i = 0; i < 5; i++) begin
            step();
            if (o_iv && o_instr_addr == a0 && o_instr_data == d0 && !o_req_valid && !o_inc) good++;
        end
        check("bp_stable_cycles", 32'(good), 32'd5);
        check("bp_no_requests", 32'(n_req - r0), 32'd0);
        check("bp_no_inc", 32'(n_inc - i0), 32'd0);
        instr_ready = 1; lat = 4; beef_next = 1;
        wait_hs(3);
        wait_req(5);
        beef_next = 0;
        check("bp_resume_addr", 32'(o_req_addr), 32'd4);

        // Branch one cycle after the request is accepted, memory latency 4
        br_valid = 1; br_target = 8'h40;
        step();
        br_valid = 0;
        check("brw_jmp", 32'(o_jmp), 32'd1);
        check("brw_jmp_addr", 32'(o_jmp_addr), 32'h40);
        r0 = n_req;
        step(); step(); step();
        check("brw_late_rsp", 32'(o_rsp), 32'd1);
        check("brw_drain_busy", 32'(o_busy), 32'd1);
        check("brw_no_req_in_drain", 32'(n_req - r0), 32'd0);
        lat = 1;
        wait_req(5);
        check("brw_redirect_addr", 32'(o_req_addr), 32'h40);
        wait_hs(10);
        check("brw_issue_data", 32'(iss_data[iss_data.size() - 1]), 32'h0000A040);

        // Branch in the same cycle as the response
        lat = 2; k0 = n_issue;
        wait_req(5);
        step();
        br_valid = 1; br_target = 8'h80;
        step();
        br_valid = 0;
        check("brc_rsp", 32'(o_rsp), 32'd1);
        check("brc_pc_inc", 32'(o_inc), 32'd0);
        check("brc_pc_jmp", 32'(o_jmp), 32'd1);
        check("brc_instr_valid", 32'(o_iv), 32'd0);
        wait_hs(12);
        check("brc_issue_addr", 32'(iss_addr[iss_addr.size() - 1]), 32'h80);
        check("brc_issue_count", 32'(n_issue - k0), 32'd1);

        // Halt at the issue handshake, branch while idle, then fetch across the wrap
        halt = 1; lat = 1;
        wait_hs(12);
        step();
        check("halt_busy", 32'(o_busy), 32'd0);
        r0 = n_req;
        for (int i = 0; i < 8; i++) step();
        check("halt_no_requests", 32'(n_req - r0), 32'd0);
        check("halt_still_idle", 32'(o_busy), 32'd0);
        br_valid = 1; br_target = 8'hFF;
        step();
        br_valid = 0;
        check("idle_br_jmp", 32'(o_jmp), 32'd1);
        check("idle_br_busy", 32'(o_busy), 32'd0);
        halt = 0;
        wait_hs(12);
        check("wrap_issue_addr", 32'(iss_addr[iss_addr.size() - 1]), 32'hFF);
        check("wrap_issue_data", 32'(iss_data[iss_data.size() - 1]), 32'h0000A0FF);
        lat = 4;
        wait_req(5);
        check("wrap_next_req", 32'(o_req_addr), 32'h00);

        // Reset while waiting, response arrives afterwards
        step();
        rst = 1; en = 0;
        step();
        rst = 0;
        step(); step();
        check("rstw_late_rsp", 32'(o_rsp), 32'd1);
        check("rstw_busy", 32'(o_busy), 32'd0);
        check("rstw_instr_valid", 32'(o_iv), 32'd0);
        check("rstw_pc_inc", 32'(o_inc), 32'd0);
        step();
        check("rstw_instr_data", 32'(o_instr_data), 32'd0);
        check("rstw_instr_valid_after", 32'(o_iv), 32'd0);

        // Random traffic against the scoreboard
        k0 = n_issue;
        for (int i = 0; i < 1500; i++) begin
            en            = ($urandom_range(0, 19) != 0);
            halt          = ($urandom_range(0, 29) == 0);
            mem_req_ready = ($urandom_range(0, 3) != 0);
            instr_ready   = ($urandom_range(0, 3) != 0);
            br_valid      = ($urandom_range(0, 11) == 0);
            br_target     = 8'($urandom);
            lat           = $urandom_range(1, 4);
            step();
        end
        br_valid = 0;
        check("rand_progress", 32'(n_issue > k0 + 50), 32'd1);
        check("one_outstanding", 32'(req_while_pend), 32'd0);
        check("flushed_never_issued", 32'(beef_seen), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequencer for the program counter.
- Issues instruction reads at the current PC over a valid/ready memory request channel and captures the response.
- Drives the PC's `inc`/`jmp` controls, and presents each fetched instruction to the decoder over a valid/ready channel.
- Handles branch redirects from execute, including discarding in-flight fetches.

Parameters:
- ADDR_WIDTH, 8, width of PC and instruction address.
- INSTR_WIDTH, 16, width of instruction word.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- en  input  1  run enable; fetching proceeds while high.
- halt  input  1  stop request; sampled in IDLE and on the ISSUE handshake.
- pc_addr  input  ADDR_WIDTH  current PC value (PC register output).
- pc_inc  output  1  PC increment strobe.
- pc_jmp  output  1  PC load strobe.
- pc_jmp_addr  output  ADDR_WIDTH  PC load value.
- mem_req_valid  output  1  read request valid.
- mem_req_ready  input  1  memory accepts request.
- mem_req_addr  output  ADDR_WIDTH  read address; equals pc_addr.
- mem_rsp_valid  input  1  read data valid; exactly one response per accepted request, any latency ≥1 cycle.
- mem_rsp_data  input  INSTR_WIDTH  read data.
- instr_valid  output  1  fetched instruction valid to decoder.
- instr_ready  input  1  decoder accepts instruction.
- instr_data  output  INSTR_WIDTH  registered instruction word.
- instr_addr  output  ADDR_WIDTH  address the instruction was fetched from.
- br_valid  input  1  redirect request, single-cycle pulse.
- br_target  input  ADDR_WIDTH  redirect target.
- busy  output  1  high whenever state ≠ IDLE.

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE; instr_data=0, instr_addr=0.
  - All strobes/valids low the following cycle.
  - Reset mid-transaction abandons it; IDLE ignores mem_rsp_valid, so a late response is dropped.
- States: IDLE, REQ, WAIT, ISSUE, DRAIN.
- IDLE: en && !halt → REQ.
- REQ:
  - mem_req_valid = !br_valid.
  - On handshake: latch instr_addr=pc_addr → WAIT.
  - mem_req_addr is stable while mem_req_valid is high.
- WAIT, on mem_rsp_valid && !br_valid:
  - instr_data ← mem_rsp_data.
  - pc_inc=1 for exactly that cycle.
  - → ISSUE.
- ISSUE:
  - instr_valid = !br_valid.
  - instr_data/instr_addr held stable until handshake.
  - On handshake: (halt || !en) → IDLE, else → REQ.
- DRAIN: on mem_rsp_valid, data discarded → REQ if en && !halt, else IDLE.
- Branch (br_valid=1 in any state):
  - pc_jmp=1 and pc_jmp_addr=br_target that cycle; else pc_jmp=0, pc_jmp_addr=0.
  - pc_inc and pc_jmp are never high together; branch wins and pc_inc is suppressed.
  - IDLE: PC loaded, stay IDLE.
  - REQ: request suppressed; stay REQ; next cycle requests at the new PC.
  - WAIT with mem_rsp_valid same cycle: response dropped → REQ/IDLE per en/halt.
  - WAIT without mem_rsp_valid: → DRAIN.
  - ISSUE: instruction dropped, no handshake → REQ/IDLE per en/halt.
  - DRAIN: stay DRAIN.
- Throughput: 1-cycle memory latency and instr_ready=1 gives one instruction per 3 cycles (REQ, WAIT, ISSUE).
- PC wrap: the PC wraps modulo 2^ADDR_WIDTH; the controller needs no special case.
- en low mid-fetch: the current fetch completes through ISSUE, then → IDLE.
- br_valid→mem_req_valid/instr_valid/pc_jmp combinational paths are permitted.

Optional Feature:
- FETCH_PERF_CNT_EN defined adds:
  - perf_issued (output, 16): count of ISSUE handshakes.
  - perf_flushed (output, 16): count of dropped responses/instructions due to br_valid.
  - Both saturate at 0xFFFF and clear on rst.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Sequential fetch:
  - Stimulus: rst, then en=1; 1-cycle memory returning data=0xA000+addr; instr_ready=1.
  - Required: instr_addr 0x00,0x01,0x02 with data 0xA000,0xA001,0xA002; one instr_valid every 3 cycles; one pc_inc per fetch.
- Backpressure:
  - Stimulus: instr_ready=0 for 5 cycles in ISSUE.
  - Required: instr_valid stays 1; data/addr stable; mem_req_valid=0; pc_inc=0; fetch resumes after handshake.
- Branch in WAIT, memory latency 4:
  - Stimulus: br_valid with br_target=0x40 one cycle after request accept; response 0xBEEF.
  - Required: pc_jmp pulse with addr 0x40; DRAIN; 0xBEEF never presented; next mem_req_addr=0x40.
- Branch coincident with mem_rsp_valid:
  - Required: pc_inc=0, pc_jmp=1; no instr_valid; next fetch at br_target.
- Wrap:
  - Stimulus: PC=0xFF fetched and issued.
  - Required: next mem_req_addr=0x00.
- Halt and reset:
  - Stimulus: halt=1 at ISSUE handshake.
  - Required: → IDLE, busy=0, no further requests.
  - Stimulus: rst mid-WAIT, then late mem_rsp_valid.
  - Required: IDLE; response ignored; instr_valid stays 0.
